// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the 4-state K=3 (7,5) Viterbi decoder:
// encoder state transition, branch outputs and adder helpers.
package viterbi_pkg;

  localparam int NUM_STATES = 4;
  localparam int K = 3;
  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  typedef logic [K-2:0] state_t;
  typedef logic [1:0]   sym_t;

  function automatic state_t next_state(input state_t s, input logic u);
    return {u, s[1]};
  endfunction

  // {c0, c1} emitted when input u is shifted into state s
  function automatic sym_t branch_out(input state_t s, input logic u);
    logic [K-1:0] sr;
    sr = {u, s};
    return {^(sr & G0), ^(sr & G1)};
  endfunction

  function automatic logic [1:0] hamming(input sym_t a, input sym_t b);
    sym_t x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

  // 2-bit ripple-carry slice: returns {cout, sum[1:0]}
  function automatic logic [2:0] rca2(input logic [1:0] a, input logic [1:0] b,
                                      input logic cin);
    logic c1;
    logic [2:0] r;
    c1   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
    r[0] = a[0] ^ b[0] ^ cin;
    r[1] = a[1] ^ b[1] ^ c1;
    r[2] = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
    return r;
  endfunction

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select cell: both candidate metrics for a single next
// state, built from chained 2-bit ripple slices, and the survivor choice.
module acs_cell
  import viterbi_pkg::*;
#(
  parameter int PM_W  = 4,
  parameter int STATE = 0
) (
  input  sym_t            rx_sym,
  input  logic [PM_W-1:0] pm_p0,
  input  logic [PM_W-1:0] pm_p1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  localparam state_t N  = state_t'(STATE);
  localparam state_t P0 = {N[0], 1'b0};
  localparam state_t P1 = {N[0], 1'b1};
  localparam int NSL   = (PM_W + 1) / 2;
  localparam int EXT_W = 2 * NSL;

  function automatic logic [EXT_W:0] ripple_add(input logic [EXT_W-1:0] a,
                                                input logic [EXT_W-1:0] b);
    logic c;
    logic [2:0] sl;
    logic [EXT_W-1:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < NSL; i++) begin
      sl = rca2(a[2*i +: 2], b[2*i +: 2], c);
      s[2*i +: 2] = sl[1:0];
      c = sl[2];
    end
    return {c, s};
  endfunction

  logic [1:0]       bm0, bm1;
  logic [EXT_W-1:0] sum0, sum1;
  logic [1:0]       carry_unused;
  logic [PM_W-1:0]  cand0, cand1;

  assign bm0 = hamming(rx_sym, branch_out(P0, N[1]));
  assign bm1 = hamming(rx_sym, branch_out(P1, N[1]));

  assign {carry_unused[0], sum0} = ripple_add(EXT_W'(pm_p0), EXT_W'(bm0));
  assign {carry_unused[1], sum1} = ripple_add(EXT_W'(pm_p1), EXT_W'(bm1));

  assign cand0 = sum0[PM_W-1:0];
  assign cand1 = sum1[PM_W-1:0];

  // strict compare: a tie keeps the even predecessor
  assign dec    = (cand1 < cand0);
  assign pm_new = dec ? cand1 : cand0;

endmodule

// File: rtl/acs_path_metric_unit.sv
// ACS stage: four acs_cells, MSB normalisation, registered path metrics,
// survivor decisions and the index of the best metric.
module acs_path_metric_unit
  import viterbi_pkg::*;
#(
  parameter int PM_W    = 4,
  parameter int PM_INIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sym_valid,
  input  logic [1:0]                 rx_sym,
  output logic                       dec_valid,
  output logic [NUM_STATES-1:0]      dec,
  output logic [1:0]                 best_state,
  output logic [NUM_STATES*PM_W-1:0] pm_flat
);

  logic [PM_W-1:0]       pm_reg  [NUM_STATES];
  logic [PM_W-1:0]       pm_acs  [NUM_STATES];
  logic [PM_W-1:0]       pm_next [NUM_STATES];
  logic [NUM_STATES-1:0] dec_acs;
  logic [NUM_STATES-1:0] msb;
  logic                  norm;

  function automatic logic [PM_W-1:0] init_pm(input int idx);
    return (idx == 0) ? '0 : PM_W'(PM_INIT);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STATES; gi++) begin : g_state
      localparam int P0 = (gi % 2) * 2;
      acs_cell #(.PM_W(PM_W), .STATE(gi)) u_acs (
        .rx_sym (rx_sym),
        .pm_p0  (pm_reg[P0]),
        .pm_p1  (pm_reg[P0+1]),
        .pm_new (pm_acs[gi]),
        .dec    (dec_acs[gi])
      );
      assign msb[gi]     = pm_acs[gi][PM_W-1];
      assign pm_next[gi] = norm ? {1'b0, pm_acs[gi][PM_W-2:0]} : pm_acs[gi];
      assign pm_flat[gi*PM_W +: PM_W] = pm_reg[gi];
    end
  endgenerate

  // all metrics past half range: drop the common MSB to keep them bounded
  assign norm = &msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STATES; i++) pm_reg[i] <= init_pm(i);
      dec       <= '0;
      dec_valid <= 1'b0;
    end else if (start) begin
      for (int i = 0; i < NUM_STATES; i++) pm_reg[i] <= init_pm(i);
      dec_valid <= 1'b0;
    end else if (sym_valid) begin
      for (int i = 0; i < NUM_STATES; i++) pm_reg[i] <= pm_next[i];
      dec       <= dec_acs;
      dec_valid <= 1'b1;
    end else begin
      dec_valid <= 1'b0;
    end
  end

  always_comb begin
    logic [PM_W-1:0] best_pm;
    best_state = 2'd0;
    best_pm    = pm_reg[0];
    for (int i = 1; i < NUM_STATES; i++) begin
      if (pm_reg[i] < best_pm) begin
        best_pm    = pm_reg[i];
        best_state = 2'(i);
      end
    end
  end

endmodule

// File: tb/tb_acs_path_metric_unit.sv
// Bench for acs_path_metric_unit: trellis reference model checked every
// cycle, plus hand-computed metric vectors for reset, start and rst.
module tb_acs_path_metric_unit;

  localparam int PM_W    = 4;
  localparam int PM_INIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sym_valid = 1'b0;
  logic [1:0]  rx_sym = 2'b00;
  logic        dec_valid;
  logic [3:0]  dec;
  logic [1:0]  best_state;
  logic [15:0] pm_flat;

  always #5 clk = ~clk;

  acs_path_metric_unit #(.PM_W(PM_W), .PM_INIT(PM_INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sym_valid  (sym_valid),
    .rx_sym     (rx_sym),
    .dec_valid  (dec_valid),
    .dec        (dec),
    .best_state (best_state),
    .pm_flat    (pm_flat)
  );

  typedef struct packed {
    logic            norm;
    logic [3:0]      dec;
    logic [3:0][7:0] pm;
  } mres_t;

  // Reference: for every next state try both predecessors, recompute the
  // encoder output from the shift register, add the Hamming distance.
  function automatic mres_t model_step(input logic [3:0][7:0] pm, input logic [1:0] rx);
    mres_t r;
    int cand[2];
    int bm;
    logic u, s1, s0, c0, c1;
    r = '0;
    for (int n = 0; n < 4; n++) begin
      u  = (n >= 2);
      s1 = ((n % 2) == 1);
      for (int j = 0; j < 2; j++) begin
        s0 = (j == 1);
        c0 = u ^ s1 ^ s0;
        c1 = u ^ s0;
        bm = int'(rx[1] != c0) + int'(rx[0] != c1);
        cand[j] = int'(pm[(n % 2) * 2 + j]) + bm;
      end
      if (cand[1] < cand[0]) begin
        r.pm[n]  = 8'(cand[1]);
        r.dec[n] = 1'b1;
      end else begin
        r.pm[n] = 8'(cand[0]);
      end
    end
    if (r.pm[0] >= 8 && r.pm[1] >= 8 && r.pm[2] >= 8 && r.pm[3] >= 8) begin
      for (int n = 0; n < 4; n++) r.pm[n] = r.pm[n] - 8'd8;
      r.norm = 1'b1;
    end
    return r;
  endfunction

  function automatic int model_best(input logic [3:0][7:0] pm);
    int b;
    b = 0;
    for (int n = 1; n < 4; n++) if (pm[n] < pm[b]) b = n;
    return b;
  endfunction

  localparam logic [3:0][7:0] PM_RST = {8'd4, 8'd4, 8'd4, 8'd0};

  logic [3:0][7:0] m_pm;
  logic [3:0]      m_dec;
  logic            m_dv;
  logic            m_norm_seen = 1'b0;
  mres_t           m_step;

  always_comb m_step = model_step(m_pm, rx_sym);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pm  <= PM_RST;
      m_dec <= '0;
      m_dv  <= 1'b0;
    end else if (start) begin
      m_pm <= PM_RST;
      m_dv <= 1'b0;
    end else if (sym_valid) begin
      m_pm  <= m_step.pm;
      m_dec <= m_step.dec;
      m_dv  <= 1'b1;
      if (m_step.norm) m_norm_seen <= 1'b1;
    end else begin
      m_dv <= 1'b0;
    end
  end

  int total = 0;
  int bad   = 0;

  logic        chk_en = 1'b0;
  int          mode = 0;
  logic [19:0] q_a[$];
  logic [19:0] q_b[$];

  logic        lit_kick = 1'b0;
  int          lit_kind = 0;
  string       lit_name = "";
  logic [15:0] lit_pm = '0;
  logic [1:0]  lit_best = '0;
  logic [3:0]  lit_dec = '0;
  logic        lit_dv = 1'b0;
  logic        lit_chk_dec = 1'b0;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  // single compare process: per-cycle model check on negedge, literal
  // expectations when the stimulus raises lit_kick
  always @(negedge clk or posedge lit_kick) begin
    if (lit_kick) begin
      if (lit_kind == 0) begin
        chk({lit_name, "_pm"}, int'(pm_flat), int'(lit_pm));
        chk({lit_name, "_best"}, int'(best_state), int'(lit_best));
        chk({lit_name, "_dv"}, int'(dec_valid), int'(lit_dv));
        if (lit_chk_dec) chk({lit_name, "_dec"}, int'(dec), int'(lit_dec));
      end else if (lit_kind == 1) begin
        chk("gap_count", q_b.size(), q_a.size());
        for (int i = 0; i < q_a.size() && i < q_b.size(); i++)
          chk("gap_seq", int'(q_b[i]), int'(q_a[i]));
      end else begin
        chk("norm_seen", int'(m_norm_seen), 1);
      end
    end else if (chk_en && !rst) begin
      chk("cyc_dv", int'(dec_valid), int'(m_dv));
      chk("cyc_dec", int'(dec), int'(m_dec));
      chk("cyc_best", int'(best_state), model_best(m_pm));
      for (int i = 0; i < 4; i++) begin
        chk("cyc_pm", int'(pm_flat[i*PM_W +: PM_W]), int'(m_pm[i]));
        chk("cyc_pm_range", int'(pm_flat[i*PM_W +: PM_W] >= 4'd14), 0);
      end
      if (dec_valid && mode == 1) q_a.push_back({dec, pm_flat});
      if (dec_valid && mode == 2) q_b.push_back({dec, pm_flat});
      $display("cyc t=%0t dv=%0b dec=%b best=%0d pm=%h", $time, dec_valid, dec, best_state, pm_flat);
    end
  end

  task automatic step(input logic v, input logic [1:0] rx, input logic st = 1'b0);
    @(negedge clk);
    sym_valid = v;
    rx_sym    = rx;
    start     = st;
  endtask

  task automatic lit(input string nm, input logic [15:0] pm, input logic [1:0] best,
                     input logic [3:0] d, input logic dv, input logic cd);
    lit_kind = 0; lit_name = nm; lit_pm = pm; lit_best = best;
    lit_dec = d; lit_dv = dv; lit_chk_dec = cd;
    #1 lit_kick = 1'b1;
    #1 lit_kick = 1'b0;
  endtask

  task automatic kick(input int kind);
    lit_kind = kind;
    #1 lit_kick = 1'b1;
    #1 lit_kick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sym_valid = 1'b0;
    start = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  logic [1:0] seq [40];

  initial begin
    #1 rst = 1'b1;
    #10 rst = 1'b0;
    chk_en = 1'b1;

    step(1'b0, 2'b00);
    lit("reset", 16'h4440, 2'd0, 4'b0000, 1'b0, 1'b1);

    // noise-free codeword for input 1,0,1,1
    step(1'b1, 2'b11);
    step(1'b1, 2'b10);
    lit("cw_s1", 16'h5052, 2'd2, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 2'b00);
    lit("cw_s2", 16'h2303, 2'd1, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 2'b01);
    lit("cw_s3", 16'h3032, 2'd2, 4'b1111, 1'b1, 1'b1);
    step(1'b0, 2'b00);
    lit("cw_s4", 16'h0323, 2'd3, 4'b0000, 1'b1, 1'b1);
    step(1'b0, 2'b00);
    lit("cw_hold", 16'h0323, 2'd3, 4'b0000, 1'b0, 1'b1);

    // single all-zero symbol: ties in states 1 and 3 keep p0
    do_reset();
    step(1'b1, 2'b00);
    step(1'b0, 2'b00);
    lit("sym00", 16'h5250, 2'd0, 4'b0000, 1'b1, 1'b1);

    do_reset();
    for (int i = 0; i < 200; i++) begin
      if (i == 80) begin
        step(1'b1, 2'($urandom_range(0, 3)), 1'b1);
        step(1'b1, 2'($urandom_range(0, 3)));
        lit("start_drop", 16'h4440, 2'd0, 4'b0000, 1'b0, 1'b0);
      end else if (i == 150) begin
        @(negedge clk);
        sym_valid = 1'b1;
        rx_sym    = 2'b10;
        #1 rst = 1'b1;
        sym_valid = 1'b0;
        lit("async_rst", 16'h4440, 2'd0, 4'b0000, 1'b0, 1'b1);
        rst = 1'b0;
      end else begin
        step(1'b1, 2'($urandom_range(0, 3)));
      end
    end
    step(1'b0, 2'b00);
    kick(2);

    for (int i = 0; i < 40; i++) seq[i] = 2'($urandom_range(0, 3));
    do_reset();
    mode = 1;
    for (int i = 0; i < 40; i++) step(1'b1, seq[i]);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    mode = 0;
    do_reset();
    mode = 2;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, seq[i]);
      repeat ($urandom_range(1, 3)) step(1'b0, 2'b00);
    end
    step(1'b0, 2'b00);
    mode = 0;
    kick(1);

    step(1'b0, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
